text_console_writer: RTL

//  CPU-side writer for the 80x30 text-mode VGA display. Accepts one ASCII byte per valid/ready

---
 rtl/console_pkg.sv | 18 +
 rtl/console_cursor.sv | 56 +++++
 rtl/text_console_writer.sv | 103 ++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// console_pkg: shared geometry defaults, ASCII codes and FSM state type for the text console writer.
package console_pkg;
    localparam int COLS_DEF   = 80;
    localparam int ROWS_DEF   = 30;
    localparam int ADDR_W_DEF = 12;
    localparam int COL_W      = 7;
    localparam int ROW_W      = 5;

    localparam logic [7:0] CLEAR_CHAR_DEF = 8'h20;
    localparam logic [7:0] ASC_BS         = 8'h08;
    localparam logic [7:0] ASC_LF         = 8'h0A;
    localparam logic [7:0] ASC_FF         = 8'h0C;
    localparam logic [7:0] ASC_CR         = 8'h0D;
    localparam logic [7:0] ASC_PRINT_LO   = 8'h20;
    localparam logic [7:0] ASC_PRINT_HI   = 8'h7E;

    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/console_cursor.sv
// console_cursor: column/row cursor counters with wrap, plus the linear text RAM address of the
// cursor and of the cell one step behind it.
module console_cursor
    import console_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_advance,
    input  logic              i_newline,
    input  logic              i_cr,
    input  logic              i_back,
    input  logic              i_home,
    output logic [COL_W-1:0]  o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_prev_addr
);
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_inc;

    assign w_row_inc = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_home) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_newline) begin
            r_col <= '0;
            r_row <= w_row_inc;
        end else if (i_cr) begin
            r_col <= '0;
        end else if (i_advance) begin
            r_col <= (r_col == COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
            r_row <= (r_col == COL_W'(COLS - 1)) ? w_row_inc : r_row;
        end else if (i_back && r_col != '0) begin
            r_col <= r_col - 1'b1;
        end else if (i_back && r_row != '0) begin
            r_col <= COL_W'(COLS - 1);
            r_row <= r_row - 1'b1;
        end
    end

    assign o_col       = r_col;
    assign o_row       = r_row;
    assign o_addr      = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);
    // Stepping back from column 0 lands on the previous row's last cell, which is addr-1.
    assign o_prev_addr = (o_addr == '0) ? '0 : o_addr - 1'b1;
endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: terminal-style byte interpreter driving the text RAM write port,
// with a full-screen clear after reset and on form feed.
module text_console_writer
    import console_pkg::*;
#(
    parameter int          COLS       = COLS_DEF,
    parameter int          ROWS       = ROWS_DEF,
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter logic [7:0]  CLEAR_CHAR = CLEAR_CHAR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [7:0]        data_out,
    output logic [ADDR_W-1:0] write_address,
    output logic              w_en,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] CELLS = ADDR_W'(COLS * ROWS);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_clr, w_clr_next, r_addr, w_addr, w_cur_addr, w_prev_addr;
    logic [7:0]        r_data, w_data;
    logic              r_we, w_we;
    logic              w_acc, w_put, w_bs, w_lf, w_cr, w_ff;

    assign w_acc = char_valid && r_state == IDLE;
    assign w_put = w_acc && char_in >= ASC_PRINT_LO && char_in <= ASC_PRINT_HI;
    assign w_bs  = w_acc && char_in == ASC_BS;
    assign w_lf  = w_acc && char_in == ASC_LF;
    assign w_cr  = w_acc && char_in == ASC_CR;
    assign w_ff  = w_acc && char_in == ASC_FF;

    console_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
        .clk         (clk),
        .rst         (rst),
        .i_advance   (w_put),
        .i_newline   (w_lf),
        .i_cr        (w_cr),
        .i_back      (w_bs),
        .i_home      (w_ff),
        .o_col       (cursor_col),
        .o_row       (cursor_row),
        .o_addr      (w_cur_addr),
        .o_prev_addr (w_prev_addr)
    );

    always_comb begin
        w_next     = r_state;
        w_clr_next = r_clr;
        w_we       = 1'b0;
        w_addr     = r_addr;
        w_data     = r_data;
        if (r_state == CLEAR) begin
            // One extra non-writing cycle at clr==CELLS so ready rises after the last write is seen.
            if (r_clr == CELLS) begin
                w_next     = IDLE;
                w_clr_next = '0;
            end else begin
                w_we       = 1'b1;
                w_addr     = r_clr;
                w_data     = CLEAR_CHAR;
                w_clr_next = r_clr + 1'b1;
            end
        end else begin
            if (w_ff) begin
                w_next     = CLEAR;
                w_clr_next = '0;
            end
            if (w_put || w_bs) begin
                w_we   = 1'b1;
                w_addr = w_bs ? w_prev_addr : w_cur_addr;
                w_data = w_bs ? CLEAR_CHAR : char_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_clr   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_clr   <= w_clr_next;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_data  <= w_data;
        end
    end

    assign char_ready    = r_state == IDLE;
    assign busy          = r_state == CLEAR;
    assign w_en          = r_we;
    assign write_address = r_addr;
    assign data_out      = r_data;
endmodule
